// File: rtl/fc_layer_if.sv
// Bus between a fully-connected output neuron and its requester/memories:
// pass handshake, shared layer-2/weight read port, bias and result.
interface fc_layer_if;
    logic        start;
    logic        busy;
    logic        lrd;
    logic [10:0] laddr;
    logic [19:0] ldata;
    logic [19:0] wdata;
    logic [19:0] bias;
    logic [19:0] result;
    logic        done;

    modport master (
        output start, ldata, wdata, bias,
        input  busy, lrd, laddr, result, done
    );

    modport slave (
        input  start, ldata, wdata, bias,
        output busy, lrd, laddr, result, done
    );
endinterface

// File: rtl/fc_layer.sv
// Single fully-connected neuron: streams N_IN layer-2/weight pairs, accumulates
// Q8.32 products, then adds bias, rounds, saturates to Q4.16 and optional ReLU.
module fc_layer #(
    parameter int N_IN    = 2048,
    parameter bit RELU_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    fc_layer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        FINAL = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [10:0] LAST_ADDR = 11'(N_IN - 1);

    state_t             state_q;
    logic               busy_q;
    logic               lrd_q;
    logic [10:0]        laddr_q;
    logic               rdv_q;
    logic               pv_q;
    logic signed [39:0] prod_q;
    logic signed [47:0] acc_q;
    logic [19:0]        result_q;
    logic               done_q;

    logic signed [39:0] ld_ext_d;
    logic signed [39:0] wd_ext_d;
    logic signed [39:0] prod_d;
    logic signed [47:0] acc_d;
    logic signed [48:0] sum_d;
    logic signed [32:0] shifted_d;
    logic [19:0]        result_d;

    // Product of the returned pair, running sum, and the rounded/saturated output value.
    always_comb begin
        ld_ext_d  = {{20{bus.ldata[19]}}, bus.ldata};
        wd_ext_d  = {{20{bus.wdata[19]}}, bus.wdata};
        prod_d    = ld_ext_d * wd_ext_d;
        acc_d     = acc_q + {{8{prod_q[39]}}, prod_q};
        sum_d     = {acc_q[47], acc_q}
                  + {{13{bus.bias[19]}}, bus.bias, 16'h0000}
                  + 49'sd32768;
        shifted_d = sum_d[48:16];
        if (!shifted_d[32] && (|shifted_d[31:19])) begin
            result_d = 20'h7FFFF;
        end else if (shifted_d[32] && !(&shifted_d[31:19])) begin
            result_d = 20'h80000;
        end else begin
            result_d = shifted_d[19:0];
        end
        if (RELU_EN && result_d[19]) begin
            result_d = 20'h00000;
        end else begin
            result_d = result_d;
        end
    end

    // Pass sequencer plus the read-data / product pipeline and accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            lrd_q    <= 1'b0;
            laddr_q  <= 11'd0;
            rdv_q    <= 1'b0;
            pv_q     <= 1'b0;
            prod_q   <= 40'sd0;
            acc_q    <= 48'sd0;
            result_q <= 20'h00000;
            done_q   <= 1'b0;
        end else begin
            // Data returning on a cycle with no issued read is replaced by zero.
            rdv_q  <= lrd_q;
            pv_q   <= rdv_q;
            prod_q <= rdv_q ? prod_d : 40'sd0;
            done_q <= 1'b0;
            if (pv_q) begin
                acc_q <= acc_d;
            end else begin
                acc_q <= acc_q;
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                        lrd_q   <= 1'b1;
                        laddr_q <= 11'd0;
                        acc_q   <= 48'sd0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FETCH: begin
                    if (laddr_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                        lrd_q   <= 1'b0;
                        laddr_q <= 11'd0;
                    end else begin
                        laddr_q <= laddr_q + 11'd1;
                    end
                end
                DRAIN: begin
                    // Last product is folded in on the edge where rdv_q has already fallen.
                    if (!rdv_q) begin
                        state_q <= FINAL;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                FINAL: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= OUT;
                end
                OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    lrd_q   <= 1'b0;
                    laddr_q <= 11'd0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.lrd    = lrd_q;
    assign bus.laddr  = laddr_q;
    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_fc_layer.sv
// Directed and randomized passes through two fc_layer instances (ReLU off/on)
// checked against an arithmetic reference model of the neuron.
module tb_fc_layer;

    localparam int N = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v;
    logic [19:0] bias_v;

    logic signed [19:0] lmem [N];
    logic signed [19:0] wmem [N];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_check = 0;

    always #5 clk = ~clk;

    fc_layer_if if0 ();
    fc_layer_if if1 ();

    fc_layer #(.N_IN(N), .RELU_EN(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    fc_layer #(.N_IN(N), .RELU_EN(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

    assign if0.start = start_v;
    assign if1.start = start_v;
    assign if0.bias  = bias_v;
    assign if1.bias  = bias_v;

    // Layer-2 memory and weight ROM: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        if0.ldata <= if0.lrd ? lmem[if0.laddr] : 20'($urandom);
        if0.wdata <= if0.lrd ? wmem[if0.laddr] : 20'($urandom);
        if1.ldata <= if1.lrd ? lmem[if1.laddr] : 20'($urandom);
        if1.wdata <= if1.lrd ? wmem[if1.laddr] : 20'($urandom);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dot product with 48-bit wrap, bias, round-half-up, saturate, optional ReLU.
    function automatic logic [19:0] model(input bit relu);
        longint acc;
        longint s;
        longint q;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            acc = acc + longint'(lmem[i]) * longint'(wmem[i]);
            acc = (acc <<< 16) >>> 16;
        end
        s = acc + longint'($signed(bias_v)) * 65536 + 32768;
        q = s >>> 16;
        if (q > 524287) q = 524287;
        else if (q < -524288) q = -524288;
        if (relu && q < 0) q = 0;
        return q[19:0];
    endfunction

    task automatic fill(input logic [19:0] l, input logic [19:0] w);
        for (int i = 0; i < N; i++) begin
            lmem[i] = l;
            wmem[i] = w;
        end
    endtask

    task automatic fill_rand(input int mask);
        for (int i = 0; i < N; i++) begin
            lmem[i] = 20'($urandom) & 20'(mask);
            wmem[i] = 20'($urandom);
        end
    endtask

    // Caller sits at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_pass(input string tag, input bit restart);
        logic [19:0] exp0;
        logic [19:0] exp1;
        int lrd_cnt  = 0;
        int addr_err = 0;
        int busy_err = 0;
        int done0    = 0;
        int done1    = 0;
        int done_cyc = -1;
        int nxt      = 0;
        exp0 = model(1'b0);
        exp1 = model(1'b1);
        start_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= N + 4; k++) begin
            start_v = (restart && (k == 500 || k == 501)) ? 1'b1 : 1'b0;
            if (if0.lrd) begin
                if (if0.laddr != 11'(nxt)) addr_err++;
                nxt++;
                lrd_cnt++;
            end else if (if0.laddr != 11'd0) begin
                addr_err++;
            end
            if (if0.busy !== (k <= N + 3)) busy_err++;
            if (if0.done) begin
                done0++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (if1.done) done1++;
            if (k < N + 4) @(negedge clk);
        end
        check({tag, "_lrd_cycles"}, lrd_cnt, N);
        check({tag, "_addr_seq"}, addr_err, 0);
        check({tag, "_busy"}, busy_err, 0);
        check({tag, "_done_cnt0"}, done0, 1);
        check({tag, "_done_cnt1"}, done1, 1);
        check({tag, "_done_cycle"}, done_cyc, N + 3);
        check({tag, "_result0"}, if0.result, exp0);
        check({tag, "_result1"}, if1.result, exp1);
    endtask

    initial begin
        reset   = 1'b1;
        start_v = 1'b0;
        bias_v  = 20'h00000;
        fill(20'h00000, 20'h00000);
        repeat (3) @(negedge clk);
        check("rst_busy", if0.busy, 1'b0);
        check("rst_lrd", if0.lrd, 1'b0);
        check("rst_done", if0.done, 1'b0);
        check("rst_result", if0.result, 20'h00000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        fill(20'h00080, 20'h10000);
        run_pass("p4", 1'b0);
        check("p4_const", if0.result, 20'h40000);

        fill(20'h00080, 20'hF0000);
        run_pass("pneg", 1'b0);
        check("pneg_const0", if0.result, 20'hC0000);
        check("pneg_const1", if1.result, 20'h00000);

        fill(20'h10000, 20'h10000);
        run_pass("psatp", 1'b0);
        check("psatp_const", if0.result, 20'h7FFFF);

        fill(20'h10000, 20'hF0000);
        run_pass("psatn", 1'b0);
        check("psatn_const", if0.result, 20'h80000);

        fill(20'h00000, 20'h10000);
        bias_v = 20'h08000;
        run_pass("pbias", 1'b0);
        check("pbias_const", if0.result, 20'h08000);

        // Abort a pass mid-fetch and confirm nothing of it survives.
        fill(20'h00080, 20'h10000);
        bias_v  = 20'h00000;
        start_v = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v = 1'b0;
        for (int k = 0; k < 3000 && if0.laddr != 11'd1000; k++) @(negedge clk);
        check("abort_reach_1000", if0.laddr, 11'd1000);
        reset = 1'b1;
        #1;
        check("abort_busy", if0.busy, 1'b0);
        check("abort_lrd", if0.lrd, 1'b0);
        check("abort_laddr", if0.laddr, 11'd0);
        check("abort_done", if0.done, 1'b0);
        check("abort_result0", if0.result, 20'h00000);
        check("abort_result1", if1.result, 20'h00000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_pass("pafter", 1'b0);
        check("pafter_const", if0.result, 20'h40000);

        fill_rand(32'hFFFFF);
        bias_v = 20'($urandom);
        run_pass("rnd_restart", 1'b1);

        fill_rand(32'h003FF);
        bias_v = 20'($urandom);
        run_pass("rnd_b2b", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
